// File: rtl/npu_seq.sv
// npu_seq: sequences a 3x3 systolic array job (skewed feed, de-skewed write-back, done pulse).
// First read 1 cycle after start, row k written at c=k+6; no backpressure; NPU_SEQ_PERF_EN adds perf_cyc.
module npu_seq #(
    parameter int DW     = 8,
    parameter int ACCW   = 16,
    parameter int AWIDTH = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [AWIDTH-1:0]   n_vec,
    output logic                busy,
    output logic                done,
    output logic                in_rd_en,
    output logic [AWIDTH-1:0]   in_rd_addr,
    input  logic [3*DW-1:0]     in_rd_data,
    output logic                arr_en,
    output logic [3*DW-1:0]     arr_left,
    input  logic [3*ACCW-1:0]   arr_down,
    output logic                out_wr_en,
    output logic [AWIDTH-1:0]   out_wr_addr,
    output logic [3*ACCW-1:0]   out_wr_data
`ifdef NPU_SEQ_PERF_EN
    ,
    output logic [15:0]         perf_cyc
`endif
);

    localparam int CW = AWIDTH + 3;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     c_q, c_d;
    logic [AWIDTH-1:0] n_q, n_d;
    logic [CW-1:0]     last_c;

    logic              vld1_q;
    logic [DW-1:0]     l1_q, l2a_q, l2b_q;
    logic [ACCW-1:0]   c0a_q, c0b_q, c1_q;

    // Final write of vector N-1 lands at c = N+5, which also ends the drain.
    assign last_c = CW'(n_q) + CW'(5);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            c_q     <= '0;
            n_q     <= '0;
        end else begin
            state_q <= state_d;
            c_q     <= c_d;
            n_q     <= n_d;
        end
    end

    always_comb begin
        state_d = state_q;
        c_d     = c_q;
        n_d     = n_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (n_vec != '0) begin
                        n_d     = n_vec;
                        c_d     = '0;
                        state_d = RUN;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            RUN: begin
                c_d = c_q + CW'(1);
                if (c_q == last_c) state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy        = (state_q != IDLE);
        done        = (state_q == DONE);
        in_rd_en    = (state_q == RUN) && (c_q < CW'(n_q));
        in_rd_addr  = in_rd_en ? AWIDTH'(c_q) : '0;
        arr_en      = (state_q == RUN) && (c_q != '0);
        out_wr_en   = (state_q == RUN) && (c_q >= CW'(6));
        out_wr_addr = out_wr_en ? AWIDTH'(c_q - CW'(6)) : '0;
        out_wr_data = out_wr_en ? {arr_down[3*ACCW-1:2*ACCW], c1_q, c0b_q} : '0;
        arr_left    = {l2b_q, l1_q, vld1_q ? in_rd_data[DW-1:0] : {DW{1'b0}}};
    end

    // Skew pipes carry zeros whenever no read data is valid, so idle lane slots drive 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld1_q <= 1'b0;
            l1_q   <= '0;
            l2a_q  <= '0;
            l2b_q  <= '0;
            c0a_q  <= '0;
            c0b_q  <= '0;
            c1_q   <= '0;
        end else begin
            vld1_q <= in_rd_en;
            l1_q   <= vld1_q ? in_rd_data[2*DW-1:DW]   : '0;
            l2a_q  <= vld1_q ? in_rd_data[3*DW-1:2*DW] : '0;
            l2b_q  <= l2a_q;
            c0a_q  <= arr_down[ACCW-1:0];
            c0b_q  <= c0a_q;
            c1_q   <= arr_down[2*ACCW-1:ACCW];
        end
    end

`ifdef NPU_SEQ_PERF_EN
    logic [15:0] perf_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_q <= '0;
        end else if ((state_q == IDLE) && start) begin
            perf_q <= '0;
        end else if (busy && (perf_q != 16'hFFFF)) begin
            perf_q <= perf_q + 16'd1;
        end
    end

    assign perf_cyc = perf_q;
`endif

endmodule

// File: tb/tb_npu_seq.sv
// Directed bench for npu_seq: input buffer model, stub array, write scoreboard with cycle-exact timing.
module tb_npu_seq;
    localparam int DW = 8, ACCW = 16, AW = 8;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic [AW-1:0]     n_vec = '0;
    logic              busy, done, in_rd_en, arr_en, out_wr_en;
    logic [AW-1:0]     in_rd_addr, out_wr_addr;
    logic [3*DW-1:0]   in_rd_data = '0;
    logic [3*DW-1:0]   arr_left;
    logic [3*ACCW-1:0] arr_down;
    logic [3*ACCW-1:0] out_wr_data;
`ifdef NPU_SEQ_PERF_EN
    logic [15:0]       perf_cyc;
`endif

    npu_seq #(.DW(DW), .ACCW(ACCW), .AWIDTH(AW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .n_vec(n_vec),
        .busy(busy), .done(done), .in_rd_en(in_rd_en), .in_rd_addr(in_rd_addr),
        .in_rd_data(in_rd_data), .arr_en(arr_en), .arr_left(arr_left),
        .arr_down(arr_down), .out_wr_en(out_wr_en), .out_wr_addr(out_wr_addr),
        .out_wr_data(out_wr_data)
`ifdef NPU_SEQ_PERF_EN
        , .perf_cyc(perf_cyc)
`endif
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Input buffer: registered read, stale data held when not strobed.
    logic [3*DW-1:0] mem [0:3];
    always @(posedge clk) if (in_rd_en) in_rd_data <= mem[in_rd_addr[1:0]];

    // Stub array: column j of the vector read at cycle t appears at t+4+j; garbage otherwise.
    logic [AW:0] hist [0:5];
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 6; i++) hist[i] <= '0;
        end else begin
            hist[0] <= {in_rd_en, in_rd_addr};
            for (int i = 1; i < 6; i++) hist[i] <= hist[i-1];
        end
    end

    function automatic logic [ACCW-1:0] col_val(input logic [AW:0] h, input int j);
        if (!h[AW]) return 16'hDEAD;
        return 16'h00AA + 16'(16'h0011 * j) + {h[AW-1:0], 8'h00};
    endfunction

    always_comb begin
        arr_down = {col_val(hist[5], 2), col_val(hist[4], 1), col_val(hist[3], 0)};
    end

    // Scoreboard of expected writes, including the absolute cycle each must occur in.
    typedef struct {
        logic [AW-1:0]     addr;
        logic [3*ACCW-1:0] data;
        int                when;
    } exp_t;
    exp_t sb[$];
    exp_t mon_e;
    int   wr_cnt = 0;
    int   done_cnt = 0;
    int   rd_cnt = 0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (done) done_cnt++;
            if (in_rd_en) rd_cnt++;
            if (out_wr_en) begin
                wr_cnt++;
                if (sb.size() == 0) begin
                    chk("wr_unexpected", {88'h0, out_wr_addr}, 96'hFFFF);
                end else begin
                    mon_e = sb.pop_front();
                    chk("wr_addr", {88'h0, out_wr_addr}, {88'h0, mon_e.addr});
                    chk("wr_data", {48'h0, out_wr_data}, {48'h0, mon_e.data});
                    chk("wr_cycle", 96'(cyc), 96'(mon_e.when));
                end
            end
        end
    end

    logic [3*ACCW-1:0] rowtab [0:3];
    int done_c, drop_c, en_cnt, en_first, en_last, rd_bad;
    logic [3*DW-1:0] al [0:31];

    task automatic run_job(input int n, input int inj_c);
        int t0;
        @(negedge clk);
        start = 1'b1;
        n_vec = AW'(n);
        @(negedge clk);
        start = 1'b0;
        n_vec = '0;
        t0 = cyc;
        for (int k = 0; k < n; k++) sb.push_back('{AW'(k), rowtab[k], t0 + k + 6});
        done_c = -1; drop_c = -1; en_cnt = 0; en_first = -1; en_last = -1; rd_bad = 0;
        for (int c = 0; c < n + 14; c++) begin
            if (done && done_c < 0) done_c = c;
            if (!busy && drop_c < 0) drop_c = c;
            if (arr_en) begin
                en_cnt++;
                if (en_first < 0) en_first = c;
                en_last = c;
            end
            if (c < 32) al[c] = arr_left;
            if (in_rd_en !== (c < n) || (c < n && in_rd_addr !== AW'(c))) rd_bad++;
            start = (c == inj_c);
            n_vec = (c == inj_c) ? AW'(7) : '0;
            @(negedge clk);
        end
        start = 1'b0;
        n_vec = '0;
    endtask

    int d0, w0, r0;

    initial begin
        mem[0] = 24'h030201; mem[1] = 24'h131211; mem[2] = 24'h232221; mem[3] = 24'h333231;
        rowtab[0] = 48'h00CC00BB00AA; rowtab[1] = 48'h01CC01BB01AA;
        rowtab[2] = 48'h02CC02BB02AA; rowtab[3] = 48'h03CC03BB03AA;

        repeat (3) @(negedge clk);
        chk("reset_outputs", {3'b0, busy, done, in_rd_en, in_rd_addr, arr_en, arr_left,
                              out_wr_en, out_wr_addr, out_wr_data}, 96'h0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // N=1 single vector
        d0 = done_cnt; w0 = wr_cnt;
        run_job(1, -1);
        chk("n1_rd", 96'(rd_bad), 96'h0);
        chk("n1_left_c1", {72'h0, al[1]}, {72'h0, 24'h000001});
        chk("n1_left_c2", {72'h0, al[2]}, {72'h0, 24'h000200});
        chk("n1_left_c3", {72'h0, al[3]}, {72'h0, 24'h030000});
        chk("n1_left_c4", {72'h0, al[4]}, 96'h0);
        chk("n1_done_c", 96'(done_c), 96'(7));
        chk("n1_busy_drop", 96'(drop_c), 96'(8));
        chk("n1_en_first", 96'(en_first), 96'(1));
        chk("n1_en_last", 96'(en_last), 96'(6));
        chk("n1_writes", 96'(wr_cnt - w0), 96'(1));
        chk("n1_dones", 96'(done_cnt - d0), 96'(1));

        // N=4 back-to-back right after the previous job
        d0 = done_cnt; w0 = wr_cnt;
        run_job(4, -1);
        chk("n4_rd", 96'(rd_bad), 96'h0);
        chk("n4_left_c3", {72'h0, al[3]}, {72'h0, 24'h031221});
        chk("n4_left_c6", {72'h0, al[6]}, {72'h0, 24'h330000});
        chk("n4_en_cnt", 96'(en_cnt), 96'(9));
        chk("n4_en_first", 96'(en_first), 96'(1));
        chk("n4_en_last", 96'(en_last), 96'(9));
        chk("n4_done_c", 96'(done_c), 96'(10));
        chk("n4_writes", 96'(wr_cnt - w0), 96'(4));
`ifdef NPU_SEQ_PERF_EN
        chk("perf_after_done", {80'h0, perf_cyc}, 96'd11);
        repeat (5) @(negedge clk);
        chk("perf_hold", {80'h0, perf_cyc}, 96'd11);
`endif

        // N=0: straight to DONE, no traffic
        d0 = done_cnt; w0 = wr_cnt; r0 = rd_cnt;
        run_job(0, -1);
        chk("n0_done_c", 96'(done_c), 96'(0));
        chk("n0_busy_drop", 96'(drop_c), 96'(1));
        chk("n0_en_cnt", 96'(en_cnt), 96'(0));
        chk("n0_reads", 96'(rd_cnt - r0), 96'(0));
        chk("n0_writes", 96'(wr_cnt - w0), 96'(0));
        chk("n0_dones", 96'(done_cnt - d0), 96'(1));

        // N=3 with start(n=7) pulsed during RUN
        d0 = done_cnt; w0 = wr_cnt;
        run_job(3, 2);
        chk("inj_writes", 96'(wr_cnt - w0), 96'(3));
        chk("inj_dones", 96'(done_cnt - d0), 96'(1));
        chk("inj_done_c", 96'(done_c), 96'(9));

        // Reset at c=3 of an N=5 job
        @(negedge clk);
        start = 1'b1; n_vec = 8'd5;
        @(negedge clk);
        start = 1'b0; n_vec = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_outputs", {3'b0, busy, done, in_rd_en, in_rd_addr, arr_en, arr_left,
                               out_wr_en, out_wr_addr, out_wr_data}, 96'h0);
        d0 = done_cnt; w0 = wr_cnt;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        chk("midrst_no_done", 96'(done_cnt - d0), 96'(0));
        chk("midrst_no_write", 96'(wr_cnt - w0), 96'(0));

        // N=2 after reset, with start pulsed in the DONE cycle
        d0 = done_cnt; w0 = wr_cnt;
        run_job(2, 8);
        chk("n2_done_c", 96'(done_c), 96'(8));
        chk("n2_writes", 96'(wr_cnt - w0), 96'(2));
        chk("n2_dones", 96'(done_cnt - d0), 96'(1));
        chk("n2_idle_after", {95'h0, busy}, 96'h0);

        chk("sb_empty", 96'(sb.size()), 96'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
